// File: rtl/axi_uram_pkg.sv
// Shared constants and FSM state type for the AXI URAM read path.
// Burst/response encodings follow the AXI4 AxBURST and xRESP fields.
package axi_uram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/axi_uram_rd_split.sv
// Splits one upstream AXI4 INCR read into sub-bursts of at most MAX_BEATS beats
// and merges the returned R beats into a single stream with one final rlast.
module axi_uram_rd_split
    import axi_uram_pkg::*;
#(
    parameter int C_S_AXI_ID_WIDTH   = 8,
    parameter int C_S_AXI_DATA_WIDTH = 1024,
    parameter int C_S_AXI_ADDR_WIDTH = 20,
    parameter int MAX_BEATS          = 16
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_aresetn,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [1:0]                    s_axi_arburst,
    input  logic [2:0]                    s_axi_arsize,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,

    output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,

    output logic [C_S_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [1:0]                    m_axi_arburst,
    output logic [2:0]                    m_axi_arsize,
    output logic [7:0]                    m_axi_arlen,
    output logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic                          m_axi_arlock,
    output logic [3:0]                    m_axi_arcache,
    output logic [2:0]                    m_axi_arprot,
    output logic [3:0]                    m_axi_arqos,

    input  logic [C_S_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    localparam int         AW    = C_S_AXI_ADDR_WIDTH;
    localparam logic [8:0] MAX_B = 9'(MAX_BEATS);

    // Only INCR bursts are split; FIXED and WRAP go out whole.
    function automatic logic [8:0] chunk_f(input logic [8:0] rem, input logic [1:0] burst);
        if (burst == BURST_INCR && rem > MAX_B) begin
            return MAX_B;
        end
        return rem;
    endfunction

    state_t                      state_q, state_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic [2:0]                  size_q, size_d;
    logic [1:0]                  burst_q, burst_d;
    logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
    logic [7:0]                  len_q, len_d;
    logic [8:0]                  rem_q, rem_d;
    logic [8:0]                  total_q, total_d;
    logic [8:0]                  rx_cnt_q, rx_cnt_d;

    logic [8:0] chunk;
    logic [8:0] new_total;
    logic       r_hs;
    logic       last_beat;
    logic       unused_rlast;

    assign unused_rlast = m_axi_rlast;

    assign chunk     = chunk_f(rem_q, burst_q);
    assign new_total = 9'(s_axi_arlen) + 9'd1;
    assign r_hs      = m_axi_rvalid & s_axi_rready;
    assign last_beat = (rx_cnt_q == total_q - 9'd1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        burst_d  = burst_q;
        id_d     = id_q;
        len_d    = len_q;
        rem_d    = rem_q;
        total_d  = total_q;
        rx_cnt_d = rx_cnt_q;

        if (r_hs) begin
            rx_cnt_d = rx_cnt_q + 9'd1;
        end

        case (state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    addr_d   = s_axi_araddr;
                    size_d   = s_axi_arsize;
                    burst_d  = s_axi_arburst;
                    id_d     = s_axi_arid;
                    total_d  = new_total;
                    rem_d    = new_total;
                    len_d    = 8'(chunk_f(new_total, s_axi_arburst) - 9'd1);
                    rx_cnt_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (m_axi_arready) begin
                    addr_d = addr_q + (AW'(chunk) << size_q);
                    rem_d  = rem_q - chunk;
                    if (rem_q == chunk) begin
                        state_d = DRAIN;
                    end else begin
                        len_d = 8'(chunk_f(rem_q - chunk, burst_q) - 9'd1);
                    end
                end
            end
            DRAIN: begin
                if (r_hs && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            id_q     <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            total_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            id_q     <= id_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            total_q  <= total_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign s_axi_arready = (state_q == IDLE);

    assign m_axi_arvalid = (state_q == ISSUE);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;
    assign m_axi_arid    = id_q;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;

    // Downstream rlast marks sub-burst ends only; the upstream one is counted here.
    assign s_axi_rvalid = m_axi_rvalid;
    assign m_axi_rready = s_axi_rready;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rvalid & last_beat;

endmodule

// File: tb/tb_axi_uram_rd_split.sv
// Scoreboard bench for axi_uram_rd_split with a small URAM slave model that
// answers each downstream AR with beats tagged by their address and id.
module tb_axi_uram_rd_split;
    import axi_uram_pkg::*;

    localparam int IDW = 8;
    localparam int DW  = 1024;
    localparam int AW  = 20;

    logic           clk;
    logic           s_axi_aresetn;
    logic [AW-1:0]  s_axi_araddr;
    logic [1:0]     s_axi_arburst;
    logic [2:0]     s_axi_arsize;
    logic [7:0]     s_axi_arlen;
    logic [IDW-1:0] s_axi_arid;
    logic           s_axi_arvalid;
    logic           s_axi_arready;
    logic [DW-1:0]  s_axi_rdata;
    logic [IDW-1:0] s_axi_rid;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic           s_axi_rvalid;
    logic           s_axi_rready;
    logic [AW-1:0]  m_axi_araddr;
    logic [1:0]     m_axi_arburst;
    logic [2:0]     m_axi_arsize;
    logic [7:0]     m_axi_arlen;
    logic [IDW-1:0] m_axi_arid;
    logic           m_axi_arvalid;
    logic           m_axi_arready;
    logic           m_axi_arlock;
    logic [3:0]     m_axi_arcache;
    logic [2:0]     m_axi_arprot;
    logic [3:0]     m_axi_arqos;
    logic [DW-1:0]  m_axi_rdata;
    logic [IDW-1:0] m_axi_rid;
    logic [1:0]     m_axi_rresp;
    logic           m_axi_rlast;
    logic           m_axi_rvalid;
    logic           m_axi_rready;

    axi_uram_rd_split #(
        .C_S_AXI_ID_WIDTH  (IDW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .MAX_BEATS         (16)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(s_axi_aresetn),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_arsize (s_axi_arsize),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arid   (s_axi_arid),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rid    (s_axi_rid),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arid   (m_axi_arid),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_arlock (m_axi_arlock),
        .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arqos  (m_axi_arqos),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rid    (m_axi_rid),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    typedef struct {
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [1:0]     burst;
        logic [2:0]     size;
        logic [IDW-1:0] id;
    } ar_t;

    typedef struct {
        logic [AW-1:0]  a;
        logic [IDW-1:0] id;
        logic           last;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];
    ar_t slv_q[$];

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    int stall_cycles = 0;
    bit rready_toggle = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [1:0] b,
                           input logic [2:0] s, input logic [IDW-1:0] id);
        ar_t e;
        e.addr = a; e.len = l; e.burst = b; e.size = s; e.id = id;
        exp_ar.push_back(e);
    endtask

    // Slave model + monitors: observe at negedge, drive 1 time unit after posedge.
    initial begin : slave_and_monitor
        ar_t           cur, prev_pl, ea;
        r_t            er;
        logic [AW-1:0] ba;
        bit            prev_stalled, chk_arready_next;
        int            slv_beat, stall_cnt;
        prev_stalled = 0; chk_arready_next = 0; slv_beat = 0; stall_cnt = 0;
        m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0; m_axi_rlast = 0;
        m_axi_arready = 1; s_axi_rready = 1;
        forever begin
            @(negedge clk);
            if (!s_axi_aresetn) begin
                slv_q.delete(); slv_beat = 0; stall_cnt = 0;
                prev_stalled = 0; chk_arready_next = 0;
            end else begin
                if (chk_arready_next) begin
                    check("arready_after_last", s_axi_arready, 1);
                    chk_arready_next = 0;
                end
                cur.addr = m_axi_araddr; cur.len = m_axi_arlen; cur.burst = m_axi_arburst;
                cur.size = m_axi_arsize; cur.id = m_axi_arid;
                if (prev_stalled && m_axi_arvalid) begin
                    check("ar_stable_addr", cur.addr, prev_pl.addr);
                    check("ar_stable_len", cur.len, prev_pl.len);
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    if (exp_ar.size() == 0) begin
                        check("ar_unexpected", 1, 0);
                    end else begin
                        ea = exp_ar.pop_front();
                        check("ar_addr", cur.addr, ea.addr);
                        check("ar_len", cur.len, ea.len);
                        check("ar_burst", cur.burst, ea.burst);
                        check("ar_size", cur.size, ea.size);
                        check("ar_id", cur.id, ea.id);
                    end
                    slv_q.push_back(cur);
                    stall_cnt = 0;
                end
                prev_stalled = m_axi_arvalid && !m_axi_arready;
                prev_pl = cur;
                if (s_axi_rvalid && s_axi_rready) begin
                    check("r_state_active", dut.state_q != IDLE, 1);
                    if (exp_r.size() == 0) begin
                        check("r_unexpected", 1, 0);
                    end else begin
                        er = exp_r.pop_front();
                        check("r_data_addr", s_axi_rdata[AW-1:0], er.a);
                        check("r_data_id", s_axi_rdata[DW-1 -: IDW], er.id);
                        check("r_id", s_axi_rid, er.id);
                        check("r_resp", s_axi_rresp, RESP_OKAY);
                        check("r_last", s_axi_rlast, er.last);
                        if (er.last) chk_arready_next = 1;
                    end
                    beats_seen++;
                end
                if (m_axi_rvalid && m_axi_rready && slv_q.size() != 0) begin
                    if (slv_beat >= int'(slv_q[0].len)) begin
                        void'(slv_q.pop_front());
                        slv_beat = 0;
                    end else begin
                        slv_beat++;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!s_axi_aresetn || slv_q.size() == 0) begin
                m_axi_rvalid = 0;
                m_axi_rlast = 0;
            end else begin
                ba = slv_q[0].addr + (AW'(slv_beat) << slv_q[0].size);
                m_axi_rdata = '0;
                m_axi_rdata[AW-1:0] = ba;
                m_axi_rdata[DW-1 -: IDW] = slv_q[0].id;
                m_axi_rid = slv_q[0].id;
                m_axi_rresp = RESP_OKAY;
                m_axi_rlast = (slv_beat == int'(slv_q[0].len));
                m_axi_rvalid = 1;
            end
            if (stall_cycles == 0) begin
                m_axi_arready = 1;
            end else begin
                m_axi_arready = (stall_cnt >= stall_cycles);
                if (m_axi_arvalid && !m_axi_arready) stall_cnt++;
            end
            s_axi_rready = rready_toggle ? !s_axi_rready : 1'b1;
        end
    end

    task automatic do_read(input logic [AW-1:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] b, input logic [IDW-1:0] id, input bit wait_done);
        r_t e;
        int n;
        for (int k = 0; k <= int'(len); k++) begin
            e.a = a + (AW'(k) << sz);
            e.id = id;
            e.last = (k == int'(len));
            exp_r.push_back(e);
        end
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arlen = len; s_axi_arsize = sz;
        s_axi_arburst = b; s_axi_arid = id; s_axi_arvalid = 1;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("ar_accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        @(negedge clk);
        check("busy_arready_low", s_axi_arready, 0);
        check("m_arvalid_next", m_axi_arvalid, 1);
        if (wait_done) begin
            n = 0;
            while (exp_r.size() != 0 && n < 3000) begin
                n++;
                @(negedge clk);
            end
            if (n >= 3000) check("r_drain_timeout", exp_r.size(), 0);
            repeat (2) @(negedge clk);
            check("ar_all_issued", exp_ar.size(), 0);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, base;
        s_axi_aresetn = 0;
        s_axi_araddr = '0; s_axi_arburst = '0; s_axi_arsize = '0;
        s_axi_arlen = '0; s_axi_arid = '0; s_axi_arvalid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_arvalid", m_axi_arvalid, 0);
        check("rst_m_araddr", m_axi_araddr, 0);
        check("rst_m_arlen", m_axi_arlen, 0);
        check("rst_rx_cnt", dut.rx_cnt_q, 0);
        check("rst_ar_consts", {m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos}, 0);
        @(posedge clk); #1;
        s_axi_aresetn = 1;
        @(negedge clk);
        check("rst_arready", s_axi_arready, 1);

        // single beat
        push_ar(20'h00100, 8'd0, BURST_INCR, 3'd7, 8'h11);
        do_read(20'h00100, 8'd0, 3'd7, BURST_INCR, 8'h11, 1);

        // 64 beats -> four 16-beat chunks
        push_ar(20'h01000, 8'd15, BURST_INCR, 3'd7, 8'h22);
        push_ar(20'h01800, 8'd15, BURST_INCR, 3'd7, 8'h22);
        push_ar(20'h02000, 8'd15, BURST_INCR, 3'd7, 8'h22);
        push_ar(20'h02800, 8'd15, BURST_INCR, 3'd7, 8'h22);
        do_read(20'h01000, 8'd63, 3'd7, BURST_INCR, 8'h22, 1);

        // 21 beats -> 16 + 5
        push_ar(20'h00000, 8'd15, BURST_INCR, 3'd7, 8'h03);
        push_ar(20'h00800, 8'd4, BURST_INCR, 3'd7, 8'h03);
        do_read(20'h00000, 8'd20, 3'd7, BURST_INCR, 8'h03, 1);

        // WRAP and FIXED forwarded unsplit
        push_ar(20'h00180, 8'd3, BURST_WRAP, 3'd7, 8'h44);
        do_read(20'h00180, 8'd3, 3'd7, BURST_WRAP, 8'h44, 1);
        push_ar(20'h00040, 8'd19, BURST_FIXED, 3'd2, 8'h45);
        do_read(20'h00040, 8'd19, 3'd2, BURST_FIXED, 8'h45, 1);

        // address wraps past the top of the 20-bit space
        push_ar(20'hFF800, 8'd15, BURST_INCR, 3'd7, 8'h66);
        push_ar(20'h00000, 8'd15, BURST_INCR, 3'd7, 8'h66);
        do_read(20'hFF800, 8'd31, 3'd7, BURST_INCR, 8'h66, 1);

        // stalled AR and throttled R
        stall_cycles = 5; rready_toggle = 1;
        push_ar(20'h04000, 8'd15, BURST_INCR, 3'd7, 8'h77);
        push_ar(20'h04800, 8'd15, BURST_INCR, 3'd7, 8'h77);
        do_read(20'h04000, 8'd31, 3'd7, BURST_INCR, 8'h77, 1);
        stall_cycles = 0; rready_toggle = 0;
        repeat (2) @(posedge clk);

        // reset mid-transaction
        base = beats_seen;
        push_ar(20'h08000, 8'd15, BURST_INCR, 3'd7, 8'h88);
        push_ar(20'h08800, 8'd15, BURST_INCR, 3'd7, 8'h88);
        do_read(20'h08000, 8'd31, 3'd7, BURST_INCR, 8'h88, 0);
        n = 0;
        while (beats_seen < base + 7 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) check("reset_test_timeout", beats_seen - base, 7);
        @(posedge clk); #1;
        s_axi_aresetn = 0;
        exp_r.delete();
        exp_ar.delete();
        @(negedge clk);
        check("mid_rst_state", dut.state_q, IDLE);
        check("mid_rst_m_arvalid", m_axi_arvalid, 0);
        check("mid_rst_rx_cnt", dut.rx_cnt_q, 0);
        @(posedge clk); #1;
        s_axi_aresetn = 1;
        @(negedge clk);
        check("post_rst_arready", s_axi_arready, 1);
        push_ar(20'h00200, 8'd0, BURST_INCR, 3'd7, 8'h5A);
        do_read(20'h00200, 8'd0, 3'd7, BURST_INCR, 8'h5A, 1);

        repeat (3) @(negedge clk);
        check("final_r_queue_empty", exp_r.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
